// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write-to-read bypass and pending-write scoreboard
module reg_file_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_busy0,
  output logic             rd_busy1,
  output logic [DEPTH-1:0] pending
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
  logic             rd_busy0_q, rd_busy0_d, rd_busy1_q, rd_busy1_d;
  logic             wr_ok, rsv_ok, rd_ok0, rd_ok1;

  // Out-of-range addresses and (optionally) r0 are treated as non-existent.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    wr_ok     = wr_en && addr_ok(wr_addr);
    rsv_ok    = rsv_en && addr_ok(rsv_addr);
    rd_ok0    = addr_ok(rd_addr0);
    rd_ok1    = addr_ok(rd_addr1);

    if (wr_ok) begin
      regs_d[wr_addr]    = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    // Reserve applied after the write so a newly issued producer wins.
    if (rsv_ok) begin
      pending_d[rsv_addr] = 1'b1;
    end

    // Reading next-state storage gives the write bypass for free.
    rd_data0_d = rd_ok0 ? regs_d[rd_addr0] : '0;
    rd_data1_d = rd_ok1 ? regs_d[rd_addr1] : '0;
    rd_busy0_d = rd_ok0 ? pending_d[rd_addr0] : 1'b0;
    rd_busy1_d = rd_ok1 ? pending_d[rd_addr1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      pending_q  <= '0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      rd_busy0_q <= 1'b0;
      rd_busy1_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pending_q  <= pending_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      rd_busy0_q <= rd_busy0_d;
      rd_busy1_q <= rd_busy1_d;
    end
  end

  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;
  assign rd_busy0 = rd_busy0_q;
  assign rd_busy1 = rd_busy1_q;
  assign pending  = pending_q;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a pending-write scoreboard, replacing the fixed 8×16 register bank in the CPU datapath. It stores DEPTH words of WIDTH bits and provides one write port (ALU writeback) and two registered read ports (operand fetch). Each read port has write-to-read bypass. Per-register pending bits let the issue logic stall on registers that have an outstanding result.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- ZERO_R0, 0, when 1, register 0 always reads 0 and ignores writes and reservations
- AW (derived localparam), $clog2(DEPTH), address width

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  writeback strobe
- wr_addr  input  AW  writeback destination
- wr_data  input  WIDTH  writeback data (ALU result)
- rsv_en  input  1  reserve strobe; marks a destination pending at issue
- rsv_addr  input  AW  register to mark pending
- rd_addr0  input  AW  operand 0 select
- rd_addr1  input  AW  operand 1 select
- rd_data0  output  WIDTH  operand 0, registered
- rd_data1  output  WIDTH  operand 1, registered
- rd_busy0  output  1  pending flag of operand 0 register, registered
- rd_busy1  output  1  pending flag of operand 1 register, registered
- pending  output  DEPTH  live pending vector, bit i is register i

## Operation
- **Storage:** DEPTH×WIDTH registers and a DEPTH-bit pending vector.
- **Valid addresses:** an address is valid when it is below DEPTH and is not (ZERO_R0=1 and address 0). Invalid addresses have these effects:
  - writes and reservations are ignored
  - reads return 0 with busy 0
- **Write:** when wr_en is high and wr_addr is valid, reg[wr_addr] is loaded with wr_data at the edge and pending[wr_addr] is cleared.
- **Reserve:** when rsv_en is high and rsv_addr is valid, pending[rsv_addr] is set at the edge.
- **Reserve and write to the same address in one cycle:** data is written and pending ends at 1. A new producer has been issued, so the reservation wins.
- **Read data (port n):** rd_dataN is loaded at each edge as follows:
  - if wr_en is high, wr_addr is valid and wr_addr equals rd_addrN, the port takes wr_data (bypass)
  - otherwise the port takes reg[rd_addrN], or 0 if rd_addrN is invalid
- **Read busy (port n):** rd_busyN is loaded with the next-state value of pending[rd_addrN], i.e. after this cycle's reserve and write are applied. It is 0 for an invalid address.
- **Port independence:** both read ports are fully independent and may address the same register.
- **pending output:** reflects the current registered vector. It is not a bypass.

## Timing
- **Reset:** while reset is low, asynchronously:
  - all registers = 0
  - pending = 0
  - rd_data0 = rd_data1 = 0
  - rd_busy0 = rd_busy1 = 0
- **Reset mid-operation:** reset asserted mid-operation clears all of the above immediately. Writes or reservations in flight are lost.
- **Leaving reset:** the first edge with reset high performs normal updates.
- **Read latency:** 1 cycle. An address presented in cycle t gives data and busy valid after the edge that ends cycle t.
- **Write-to-read visibility:** a write in cycle t is visible on a read issued in cycle t through the bypass. It is visible in storage from cycle t+1.
- **Pending update:** a pending bit changes on the edge ending the cycle in which rsv_en or wr_en is asserted. It is visible on the pending output in the next cycle.
- **Throughput:** one write, one reserve and two reads per cycle. There are no stalls and no back-pressure.

## Test plan
- **Reset values:** assert reset low mid-run after writing 0xBEEF to r3 and reserving r5 -> immediately rd_data0/1=0, rd_busy0/1=0, pending=0. Reading r3 after release -> 0x0000.
- **Write then read:** write 0x1234 to r2 in cycle t, rd_addr0=2 in cycle t+1 -> rd_data0=0x1234 after the t+1 edge. rd_addr1=7 (never written) -> 0x0000.
- **Bypass:** wr_en=1, wr_addr=4, wr_data=0xA5A5 and rd_addr0=rd_addr1=4 in the same cycle -> both ports read 0xA5A5 after that edge.
- **Scoreboard:**
  - rsv r6 in cycle t -> pending[6]=1 in t+1, and a read of r6 in t gives rd_busy=1.
  - write r6 in t+3 -> a read of r6 in t+3 gives rd_busy=0, and pending[6]=0 in t+4.
  - rsv and write r1 in the same cycle -> pending[1]=1 and r1 holds the new data.
- **ZERO_R0=1:** write 0xFFFF to r0 and reserve r0 -> reads of r0 return 0, busy 0, pending[0] stays 0.
- **DEPTH=6, WIDTH=32:** write to address 7 -> no register changes. Reading address 6 -> data 0, busy 0. r5 write/read of 0xDEADBEEF round-trips.
